square_move_serializer: RTL and testbench

Consumer end of the per-square move-word interface. Each board square emits sixteen 32-bit move words: eight sliding directions and eight knight jumps. `32'h0000_0000` marks an empty slot. This block latches one square's sixteen words in a single load. It then presents the non-empty ones one at a time on a valid/ready stream, lowest slot first, to the downstream move list / search logic. It sits between the square array's move outputs and the move FIFO.

---
 rtl/chess_pkg.sv | 53 +++++
 rtl/square_move_serializer_if.sv | 30 +++
 rtl/slot_prio_enc.sv | 20 ++
 rtl/square_move_serializer.sv | 105 ++++++++++
 tb/tb_square_move_serializer.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/chess_pkg.sv
// Shared move-word definitions for the square array and its move consumers.
// Holds move width/slot count, field offsets, slot order, piece codes and the
// serializer state encoding. No ports; imported with chess_pkg::*.
package chess_pkg;

  localparam int MOVE_W     = 32;
  localparam int NUM_SLOTS  = 16;
  localparam int PEND_W     = 5;   // holds 0..NUM_SLOTS
  localparam int FIELD_W    = 6;

  localparam logic [MOVE_W-1:0] EMPTY_MOVE = '0;

  // Move word field offsets (each field is FIELD_W bits wide)
  localparam int CAPT_PIECE_LSB = 24;
  localparam int FINAL_POS_LSB  = 16;
  localparam int INIT_PIECE_LSB = 8;
  localparam int INIT_POS_LSB   = 0;

  // Slot order: sliding directions, then knight jumps
  localparam int SLOT_U   = 0;
  localparam int SLOT_D   = 1;
  localparam int SLOT_L   = 2;
  localparam int SLOT_R   = 3;
  localparam int SLOT_UL  = 4;
  localparam int SLOT_UR  = 5;
  localparam int SLOT_DL  = 6;
  localparam int SLOT_DR  = 7;
  localparam int SLOT_UUL = 8;
  localparam int SLOT_UUR = 9;
  localparam int SLOT_LLU = 10;
  localparam int SLOT_RRU = 11;
  localparam int SLOT_DDL = 12;
  localparam int SLOT_DDR = 13;
  localparam int SLOT_LLD = 14;
  localparam int SLOT_RRD = 15;

  // Piece codes (bits 4:0); bit 5 of a piece field is the colour
  localparam logic [4:0] PIECE_PAWN   = 5'b00010;
  localparam logic [4:0] PIECE_KNIGHT = 5'b00001;
  localparam logic [4:0] PIECE_BISHOP = 5'b01000;
  localparam logic [4:0] PIECE_ROOK   = 5'b10000;
  localparam logic [4:0] PIECE_QUEEN  = 5'b11000;
  localparam logic [4:0] PIECE_KING   = 5'b00100;
  localparam int         COLOUR_BIT   = 5;
  localparam logic       WHITE        = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/square_move_serializer_if.sv
// Load and move-stream signals between the square array, the serializer and
// the move FIFO. master = serializer (captures move_bus, drives move stream);
// slave = surrounding logic (drives load/move_bus/move_ready).
interface square_move_serializer_if #(
  parameter int NUM_SLOTS = 16,
  parameter int MOVE_W    = 32,
  parameter int CNT_W     = 16,
  parameter int PEND_W    = 5
);
  logic                        load;
  logic [NUM_SLOTS*MOVE_W-1:0] move_bus;
  logic                        load_ready;
  logic                        move_valid;
  logic [MOVE_W-1:0]           move_data;
  logic                        move_last;
  logic                        move_ready;
  logic                        done;
  logic [PEND_W-1:0]           pending;
  logic [CNT_W-1:0]            total_moves;

  modport master (
    input  load, move_bus, move_ready,
    output load_ready, move_valid, move_data, move_last, done, pending, total_moves
  );

  modport slave (
    output load, move_bus, move_ready,
    input  load_ready, move_valid, move_data, move_last, done, pending, total_moves
  );
endinterface

// File: rtl/slot_prio_enc.sv
// Lowest-set-bit priority encoder over the slot mask.
// Purely combinational, no latency; no handshake.
// Ports: mask in; idx = lowest set index, any = mask non-zero.
module slot_prio_enc #(
  parameter int NUM_SLOTS = 16,
  parameter int IDX_W     = 4
) (
  input  logic [NUM_SLOTS-1:0] mask,
  output logic [IDX_W-1:0]     idx,
  output logic                 any
);
  always_comb begin
    idx = '0;
    any = |mask;
    // Walk downward so the lowest set bit is the last one written
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (mask[i]) idx = IDX_W'(i);
    end
  end
endmodule

// File: rtl/square_move_serializer.sv
// Captures one square's move words in a single load and streams the non-empty
// ones lowest slot first. Latency: first move the cycle after the load edge.
// Backpressure: move_ready low stalls with data held; enable low freezes all.
// Ports: clk, clear (sync, active-high), enable, mif (master modport).
module square_move_serializer
  import chess_pkg::*;
#(
  parameter int NUM_SLOTS = 16,
  parameter int MOVE_W    = 32,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      clear,
  input  logic                      enable,
  square_move_serializer_if.master  mif
);
  localparam int IDX_W = $clog2(NUM_SLOTS);

  state_e                             state_q, state_d;
  logic [NUM_SLOTS-1:0][MOVE_W-1:0]   buf_q, buf_d;
  logic [NUM_SLOTS-1:0]               mask_q, mask_d;
  logic [PEND_W-1:0]                  pending_q, pending_d;
  logic [CNT_W-1:0]                   total_q, total_d;

  logic [NUM_SLOTS-1:0] load_mask;
  logic [PEND_W-1:0]    load_cnt;
  logic [IDX_W-1:0]     head_idx;
  logic                 head_any;

  slot_prio_enc #(
    .NUM_SLOTS (NUM_SLOTS),
    .IDX_W     (IDX_W)
  ) u_prio (
    .mask (mask_q),
    .idx  (head_idx),
    .any  (head_any)
  );

  // Occupancy and count of the word set currently on move_bus
  always_comb begin
    load_mask = '0;
    load_cnt  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      load_mask[i] = |mif.move_bus[MOVE_W*i +: MOVE_W];
      load_cnt     = load_cnt + PEND_W'(load_mask[i]);
    end
  end

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    mask_d    = mask_q;
    pending_d = pending_q;
    total_d   = total_q;
    if (enable) begin
      case (state_q)
        ST_IDLE: begin
          if (mif.load) begin
            buf_d     = mif.move_bus;
            mask_d    = load_mask;
            pending_d = load_cnt;
            state_d   = (|load_mask) ? ST_SCAN : ST_DONE;
          end
        end
        ST_SCAN: begin
          if (mif.move_ready) begin
            mask_d[head_idx] = 1'b0;
            pending_d        = pending_q - PEND_W'(1);
            total_d          = total_q + CNT_W'(1);
            if (pending_q == PEND_W'(1)) state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= ST_IDLE;
      buf_q     <= '0;
      mask_q    <= '0;
      pending_q <= '0;
      total_q   <= '0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      mask_q    <= mask_d;
      pending_q <= pending_d;
      total_q   <= total_d;
    end
  end

  // Every output decodes registered state only; head_any is implied by SCAN
  // but gating on it keeps move_valid honest if the mask ever empties early.
  assign mif.load_ready  = (state_q == ST_IDLE);
  assign mif.move_valid  = (state_q == ST_SCAN) && head_any;
  assign mif.move_data   = (state_q == ST_SCAN) ? buf_q[head_idx] : '0;
  assign mif.move_last   = (state_q == ST_SCAN) && (pending_q == PEND_W'(1));
  assign mif.done        = (state_q == ST_DONE);
  assign mif.pending     = pending_q;
  assign mif.total_moves = total_q;

endmodule

// File: tb/tb_square_move_serializer.sv
// Directed bench for square_move_serializer: reset, single move, ordering,
// backpressure, empty load, clear mid-load, enable freeze and counter wrap.
module tb_square_move_serializer;
  import chess_pkg::*;

  logic clk;
  logic clear;
  logic enable;
  int   checks;
  int   errors;

  localparam logic [31:0] W_Q = 32'h0014_181C;
  localparam logic [31:0] W_A = 32'h0008_0210;
  localparam logic [31:0] W_B = 32'h0123_1807;
  localparam logic [31:0] W_C = 32'h0011_0113;

  square_move_serializer_if #(.CNT_W(16)) mif ();
  square_move_serializer_if #(.CNT_W(4))  mif2 ();

  square_move_serializer #(.NUM_SLOTS(16), .MOVE_W(32), .CNT_W(16)) dut (
    .clk(clk), .clear(clear), .enable(enable), .mif(mif)
  );

  // Narrow counter instance so wrap-around is reachable in a short run
  square_move_serializer #(.NUM_SLOTS(16), .MOVE_W(32), .CNT_W(4)) dut_w (
    .clk(clk), .clear(clear), .enable(enable), .mif(mif2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    clear = 1'b1;
    mif.load = 1'b0;
    mif2.load = 1'b0;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (mif.load_ready !== 1'b1) begin errors++; $display("FAIL rst_load_ready got=%b exp=1", mif.load_ready); end
    checks++; if (mif.move_valid !== 1'b0) begin errors++; $display("FAIL rst_move_valid got=%b exp=0", mif.move_valid); end
    checks++; if (mif.move_last !== 1'b0) begin errors++; $display("FAIL rst_move_last got=%b exp=0", mif.move_last); end
    checks++; if (mif.done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", mif.done); end
    checks++; if (mif.move_data !== 32'h0) begin errors++; $display("FAIL rst_move_data got=%h exp=0", mif.move_data); end
    checks++; if (mif.pending !== 5'd0) begin errors++; $display("FAIL rst_pending got=%0d exp=0", mif.pending); end
    checks++; if (mif.total_moves !== 16'd0) begin errors++; $display("FAIL rst_total got=%0d exp=0", mif.total_moves); end
  endtask

  task automatic test_single_move;
    do_reset();
    mif.move_bus = '0;
    mif.move_bus[32*SLOT_R +: 32] = W_Q;
    mif.move_ready = 1'b1;
    mif.load = 1'b1;
    tick();
    mif.load = 1'b0;
    checks++; if (mif.move_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", mif.move_valid); end
    checks++; if (mif.move_last !== 1'b1) begin errors++; $display("FAIL single_last got=%b exp=1", mif.move_last); end
    checks++; if (mif.move_data !== W_Q) begin errors++; $display("FAIL single_data got=%h exp=%h", mif.move_data, W_Q); end
    checks++; if (mif.load_ready !== 1'b0) begin errors++; $display("FAIL single_load_ready got=%b exp=0", mif.load_ready); end
    tick();
    checks++; if (mif.done !== 1'b1) begin errors++; $display("FAIL single_done got=%b exp=1", mif.done); end
    checks++; if (mif.move_valid !== 1'b0) begin errors++; $display("FAIL single_valid_after got=%b exp=0", mif.move_valid); end
    checks++; if (mif.total_moves !== 16'd1) begin errors++; $display("FAIL single_total got=%0d exp=1", mif.total_moves); end
    checks++; if (mif.pending !== 5'd0) begin errors++; $display("FAIL single_pending got=%0d exp=0", mif.pending); end
    tick();
    checks++; if (mif.done !== 1'b0) begin errors++; $display("FAIL single_done_pulse got=%b exp=0", mif.done); end
    checks++; if (mif.load_ready !== 1'b1) begin errors++; $display("FAIL single_idle got=%b exp=1", mif.load_ready); end
  endtask

  task automatic load_three;
    mif.move_bus = '0;
    mif.move_bus[32*SLOT_D   +: 32] = W_A;
    mif.move_bus[32*SLOT_DL  +: 32] = W_B;
    mif.move_bus[32*SLOT_UUR +: 32] = W_C;
    mif.load = 1'b1;
    tick();
    mif.load = 1'b0;
  endtask

  task automatic test_ordering;
    logic [31:0] exp_d [3];
    exp_d[0] = W_A; exp_d[1] = W_B; exp_d[2] = W_C;
    do_reset();
    mif.move_ready = 1'b1;
    load_three();
    for (int i = 0; i < 3; i++) begin
      checks++; if (mif.move_valid !== 1'b1) begin errors++; $display("FAIL order_valid[%0d] got=%b exp=1", i, mif.move_valid); end
      checks++; if (mif.move_data !== exp_d[i]) begin errors++; $display("FAIL order_data[%0d] got=%h exp=%h", i, mif.move_data, exp_d[i]); end
      checks++; if (mif.move_last !== (i == 2)) begin errors++; $display("FAIL order_last[%0d] got=%b exp=%b", i, mif.move_last, (i == 2)); end
      checks++; if (mif.pending !== 5'(3 - i)) begin errors++; $display("FAIL order_pending[%0d] got=%0d exp=%0d", i, mif.pending, 3 - i); end
      tick();
    end
    checks++; if (mif.done !== 1'b1) begin errors++; $display("FAIL order_done got=%b exp=1", mif.done); end
    checks++; if (mif.pending !== 5'd0) begin errors++; $display("FAIL order_pending_end got=%0d exp=0", mif.pending); end
    checks++; if (mif.total_moves !== 16'd3) begin errors++; $display("FAIL order_total got=%0d exp=3", mif.total_moves); end
    tick();
  endtask

  task automatic test_backpressure;
    logic [31:0] exp_d [3];
    int   n;
    logic tog;
    exp_d[0] = W_A; exp_d[1] = W_B; exp_d[2] = W_C;
    do_reset();
    mif.move_ready = 1'b0;
    load_three();
    for (int i = 0; i < 4; i++) begin
      checks++; if (mif.move_valid !== 1'b1 || mif.move_data !== W_A || mif.move_last !== 1'b0)
        begin errors++; $display("FAIL bp_stall[%0d] got v=%b d=%h l=%b exp v=1 d=%h l=0", i, mif.move_valid, mif.move_data, mif.move_last, W_A); end
      tick();
    end
    n = 0;
    tog = 1'b1;
    for (int c = 0; c < 20 && mif.done !== 1'b1; c++) begin
      mif.move_ready = tog;
      if (mif.move_valid === 1'b1) begin
        checks++;
        if (n > 2) begin
          errors++; $display("FAIL bp_extra got=transfer %0d exp=at most 3", n + 1);
        end else if (mif.move_data !== exp_d[n] || mif.move_last !== (n == 2)) begin
          errors++; $display("FAIL bp_data[%0d] got d=%h l=%b exp d=%h l=%b", n, mif.move_data, mif.move_last, exp_d[n], (n == 2));
        end
        if (tog) n++;
      end
      tog = ~tog;
      tick();
    end
    mif.move_ready = 1'b1;
    checks++; if (n != 3) begin errors++; $display("FAIL bp_count got=%0d exp=3", n); end
    checks++; if (mif.done !== 1'b1) begin errors++; $display("FAIL bp_done got=%b exp=1", mif.done); end
    checks++; if (mif.total_moves !== 16'd3) begin errors++; $display("FAIL bp_total got=%0d exp=3", mif.total_moves); end
    tick();
  endtask

  task automatic test_empty;
    do_reset();
    mif.move_bus = '0;
    mif.move_ready = 1'b1;
    mif.load = 1'b1;
    tick();
    checks++; if (mif.move_valid !== 1'b0) begin errors++; $display("FAIL empty_valid got=%b exp=0", mif.move_valid); end
    checks++; if (mif.done !== 1'b1) begin errors++; $display("FAIL empty_done got=%b exp=1", mif.done); end
    checks++; if (mif.load_ready !== 1'b0) begin errors++; $display("FAIL empty_load_ready_t1 got=%b exp=0", mif.load_ready); end
    // load held high with real data during DONE: must be ignored
    mif.move_bus[32*SLOT_U +: 32] = W_A;
    tick();
    mif.load = 1'b0;
    mif.move_bus = '0;
    checks++; if (mif.load_ready !== 1'b1) begin errors++; $display("FAIL empty_load_ready_t2 got=%b exp=1", mif.load_ready); end
    checks++; if (mif.done !== 1'b0) begin errors++; $display("FAIL empty_done_pulse got=%b exp=0", mif.done); end
    tick();
    checks++; if (mif.move_valid !== 1'b0) begin errors++; $display("FAIL done_load_ignored got valid=%b exp=0", mif.move_valid); end
    checks++; if (mif.pending !== 5'd0) begin errors++; $display("FAIL empty_pending got=%0d exp=0", mif.pending); end
  endtask

  task automatic test_clear_mid;
    do_reset();
    mif.move_bus = '0;
    mif.move_bus[32*SLOT_U   +: 32] = 32'h0000_0101;
    mif.move_bus[32*SLOT_L   +: 32] = 32'h0000_0202;
    mif.move_bus[32*SLOT_UL  +: 32] = 32'h0000_0303;
    mif.move_bus[32*SLOT_DR  +: 32] = 32'h0000_0404;
    mif.move_bus[32*SLOT_RRD +: 32] = 32'h0000_0505;
    mif.move_ready = 1'b1;
    mif.load = 1'b1;
    tick();
    mif.load = 1'b0;
    checks++; if (mif.pending !== 5'd5) begin errors++; $display("FAIL clr_pending_load got=%0d exp=5", mif.pending); end
    tick();
    tick();
    checks++; if (mif.move_data !== 32'h0000_0303 || mif.total_moves !== 16'd2)
      begin errors++; $display("FAIL clr_before got d=%h t=%0d exp d=00000303 t=2", mif.move_data, mif.total_moves); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (mif.load_ready !== 1'b1) begin errors++; $display("FAIL clr_idle got=%b exp=1", mif.load_ready); end
    checks++; if (mif.move_valid !== 1'b0) begin errors++; $display("FAIL clr_valid got=%b exp=0", mif.move_valid); end
    checks++; if (mif.pending !== 5'd0) begin errors++; $display("FAIL clr_pending got=%0d exp=0", mif.pending); end
    checks++; if (mif.total_moves !== 16'd0) begin errors++; $display("FAIL clr_total got=%0d exp=0", mif.total_moves); end
    checks++; if (mif.done !== 1'b0) begin errors++; $display("FAIL clr_done got=%b exp=0", mif.done); end
    tick();
    checks++; if (mif.done !== 1'b0 || mif.move_valid !== 1'b0)
      begin errors++; $display("FAIL clr_after got done=%b valid=%b exp 0 0", mif.done, mif.move_valid); end
  endtask

  task automatic test_enable_freeze;
    do_reset();
    mif.move_ready = 1'b1;
    load_three();
    tick();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (mif.move_valid !== 1'b1 || mif.move_data !== W_B || mif.move_last !== 1'b0)
        begin errors++; $display("FAIL frz_out[%0d] got v=%b d=%h l=%b exp v=1 d=%h l=0", i, mif.move_valid, mif.move_data, mif.move_last, W_B); end
      checks++; if (mif.pending !== 5'd2 || mif.total_moves !== 16'd1)
        begin errors++; $display("FAIL frz_cnt[%0d] got p=%0d t=%0d exp p=2 t=1", i, mif.pending, mif.total_moves); end
    end
    enable = 1'b1;
    tick();
    checks++; if (mif.move_data !== W_C || mif.move_last !== 1'b1)
      begin errors++; $display("FAIL frz_resume got d=%h l=%b exp d=%h l=1", mif.move_data, mif.move_last, W_C); end
    tick();
    enable = 1'b0;
    tick();
    tick();
    checks++; if (mif.done !== 1'b1 || mif.total_moves !== 16'd3)
      begin errors++; $display("FAIL frz_done_held got done=%b t=%0d exp done=1 t=3", mif.done, mif.total_moves); end
    enable = 1'b1;
    tick();
    checks++; if (mif.load_ready !== 1'b1 || mif.done !== 1'b0)
      begin errors++; $display("FAIL frz_idle got rdy=%b done=%b exp 1 0", mif.load_ready, mif.done); end
  endtask

  task automatic test_wrap;
    do_reset();
    for (int i = 0; i < 16; i++) mif2.move_bus[32*i +: 32] = 32'h0001_0800 + 32'(i);
    mif2.move_ready = 1'b1;
    mif2.load = 1'b1;
    tick();
    mif2.load = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++; if (mif2.move_data !== 32'h0001_0800 + 32'(i) || mif2.pending !== 5'(16 - i) || mif2.move_last !== (i == 15))
        begin errors++; $display("FAIL wrap_stream[%0d] got d=%h p=%0d l=%b exp d=%h p=%0d l=%b", i, mif2.move_data, mif2.pending, mif2.move_last, 32'h0001_0800 + 32'(i), 16 - i, (i == 15)); end
      if (i == 15) begin
        checks++; if (mif2.total_moves !== 4'hF) begin errors++; $display("FAIL wrap_max got=%h exp=f", mif2.total_moves); end
      end
      tick();
    end
    checks++; if (mif2.total_moves !== 4'h0) begin errors++; $display("FAIL wrap_zero got=%h exp=0", mif2.total_moves); end
    checks++; if (mif2.done !== 1'b1) begin errors++; $display("FAIL wrap_done got=%b exp=1", mif2.done); end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear = 1'b1;
    enable = 1'b1;
    mif.load = 1'b0;
    mif.move_bus = '0;
    mif.move_ready = 1'b0;
    mif2.load = 1'b0;
    mif2.move_bus = '0;
    mif2.move_ready = 1'b1;
    test_reset();
    test_single_move();
    test_ordering();
    test_backpressure();
    test_empty();
    test_clear_mid();
    test_enable_freeze();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
